// File: rtl/pdm_mic_rx.sv
// PDM microphone receiver: bit-clock generation, 2-flop input sync, boxcar decimation
// to 8-bit unsigned samples, valid/ready holding register. Define PDM_PEAK_EN for peak meter.
module pdm_mic_rx #(
  parameter int CLK_DIV_HALF = 25,
  parameter int DEC          = 256
) (
  input  logic       clk,
  input  logic       CPU_RESETN,
  input  logic       en,
  output logic       M_CLK,
  output logic       M_LRSEL,
  input  logic       M_DATA,
  output logic [7:0] sample,
  output logic       sample_valid,
  input  logic       sample_ready,
  output logic       overrun,
  input  logic       overrun_clr,
  output logic [7:0] peak_level,
  input  logic       peak_clr
);

  localparam int DIV_W    = $clog2(CLK_DIV_HALF + 1);
  localparam int LOG2_DEC = $clog2(DEC);
  localparam int CNT_W    = LOG2_DEC + 1;

  // raw ones count scaled to the 0..255 duty range; a full window (raw == DEC) clips to 255
  function automatic logic [7:0] scale_sat(input logic [CNT_W-1:0] raw);
    logic [CNT_W+7:0] wide;
    wide = {raw, 8'd0} >> LOG2_DEC;
    if (|wide[CNT_W+7:8]) scale_sat = 8'hFF;
    else                  scale_sat = wide[7:0];
  endfunction

  logic [1:0]          rst_sync;
  logic                rst_n;
  logic                m_data_s1, m_data_s2;
  logic [DIV_W-1:0]    div_cnt;
  logic                div_wrap, bit_stb, win_last;
  logic [LOG2_DEC-1:0] bit_cnt;
  logic [CNT_W-1:0]    ones_cnt;
  logic                vld_p0;
  logic [7:0]          samp_p0;
  logic                overrun_set;

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) rst_sync <= 2'b00;
    else             rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge clk) begin
    m_data_s1 <= M_DATA;
    m_data_s2 <= m_data_s1;
  end

  assign M_LRSEL  = 1'b0;
  assign div_wrap = en && (div_cnt == DIV_W'(CLK_DIV_HALF - 1));
  // falling edge of M_CLK: end of the high phase, left-channel data is settled
  assign bit_stb  = div_wrap && M_CLK;
  assign win_last = (bit_cnt == LOG2_DEC'(DEC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      M_CLK   <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      M_CLK   <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      M_CLK   <= ~M_CLK;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // stage p0: ones counting, window close
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      ones_cnt <= '0;
      vld_p0   <= 1'b0;
    end else begin
      vld_p0 <= 1'b0;
      if (!en) begin
        bit_cnt  <= '0;
        ones_cnt <= '0;
      end else if (bit_stb) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (win_last) begin
          ones_cnt <= '0;
          vld_p0   <= 1'b1;
        end else begin
          ones_cnt <= ones_cnt + CNT_W'(m_data_s2);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bit_stb && win_last) samp_p0 <= scale_sat(ones_cnt + CNT_W'(m_data_s2));
  end

  // stage p1: holding register and handshake
  assign overrun_set = vld_p0 && sample_valid && !sample_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (vld_p0) begin
        sample       <= samp_p0;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      overrun <= overrun_set | (overrun & ~overrun_clr);
    end
  end

`ifdef PDM_PEAK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_level <= '0;
    end else if (vld_p0) begin
      if (peak_clr || (samp_p0 > peak_level)) peak_level <= samp_p0;
    end else if (peak_clr) begin
      peak_level <= '0;
    end
  end
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak_level      = '0;
`endif

endmodule
